// File: rtl/glitchless_div_mux_if.sv
// Selection handshake, divisor configuration and clock outputs of glitchless_div_mux.
interface glitchless_div_mux_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DIV_W   = 4
);
  localparam int unsigned SW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*DIV_W-1:0] DIV_CFG;
  logic [SW-1:0]            SEL;
  logic                     SEL_VALID;
  logic                     SEL_READY;
  logic                     SEL_ERR;
  logic [SW-1:0]            ACTIVE_SEL;
  logic                     BUSY;
  logic                     CLK_OUT;
  logic                     CLK_EN;

  // Requester side: programs divisors and issues selection requests.
  modport master (
    output DIV_CFG, SEL, SEL_VALID,
    input  SEL_READY, SEL_ERR, ACTIVE_SEL, BUSY, CLK_OUT, CLK_EN
  );

  // Clock selector side.
  modport slave (
    input  DIV_CFG, SEL, SEL_VALID,
    output SEL_READY, SEL_ERR, ACTIVE_SEL, BUSY, CLK_OUT, CLK_EN
  );
endinterface

// File: rtl/glitchless_div_mux.sv
// Glitchless selector of NUM_SRC divided clocks derived from CLK.
// Switches only at the end of a full period of the old source.
// Optional feature macro: GLITCHLESS_DIV_GAP_EN inserts GAP_CYCLES low cycles on a switch.
module glitchless_div_mux #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned RESET_SEL  = 0,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  glitchless_div_mux_if.slave bus
);
  localparam int unsigned SW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PW = DIV_W + 1;

  if (NUM_SRC < 2 || NUM_SRC > 16 || RESET_SEL >= NUM_SRC || GAP_CYCLES < 1) begin : g_bad_param
    $error("glitchless_div_mux: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_GAP} state_t;

  state_t          state_q;
  logic [PW-1:0]   cnt_q;
  logic [PW-1:0]   p_q;
  logic [PW-1:0]   h_q;
  logic            clk_out_q;
  logic            clk_en_q;
  logic            sel_ready_q;
  logic            sel_err_q;
  logic            busy_q;
  logic            pend_q;
  logic [SW-1:0]   pend_sel_q;
  logic [SW-1:0]   active_q;
`ifdef GLITCHLESS_DIV_GAP_EN
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0]   gap_cnt_q;
`endif

  logic [DIV_W-1:0] div_c;
  logic [PW-1:0]    p_new_c;
  logic [PW-1:0]    h_new_c;
  logic             boundary_c;
  logic             accept_c;
  logic             sel_oob_c;
  logic             sel_same_c;

  // Divisor of the active source; period and high length derived from it.
  always_comb begin
    div_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_q == SW'(i)) div_c = bus.DIV_CFG[i*DIV_W +: DIV_W];
    end
    p_new_c    = PW'(div_c) + PW'(2);
    h_new_c    = p_new_c >> 1;
    boundary_c = (cnt_q == p_q - PW'(1));
    accept_c   = bus.SEL_VALID & sel_ready_q;
    sel_oob_c  = (32'(bus.SEL) >= NUM_SRC);
    sel_same_c = (bus.SEL == active_q);
  end

  // Period sequencer, switch FSM and handshake; every output is registered here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_START;
      cnt_q       <= '0;
      p_q         <= PW'(2);
      h_q         <= PW'(1);
      clk_out_q   <= 1'b0;
      clk_en_q    <= 1'b0;
      sel_ready_q <= 1'b0;
      sel_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      active_q    <= SW'(RESET_SEL);
`ifdef GLITCHLESS_DIV_GAP_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      clk_en_q  <= 1'b0;
      sel_err_q <= 1'b0;
      case (state_q)
        ST_START: begin
          p_q         <= p_new_c;
          h_q         <= h_new_c;
          cnt_q       <= '0;
          clk_out_q   <= 1'b1;
          clk_en_q    <= 1'b1;
          busy_q      <= 1'b0;
          pend_q      <= 1'b0;
          sel_ready_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (boundary_c && pend_q) begin
            // End of the old source's low phase: hand over to the pending source.
            active_q  <= pend_sel_q;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
`ifdef GLITCHLESS_DIV_GAP_EN
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
`else
            state_q   <= ST_START;
`endif
          end else if (boundary_c) begin
            p_q       <= p_new_c;
            h_q       <= h_new_c;
            cnt_q     <= '0;
            clk_out_q <= 1'b1;
            clk_en_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + PW'(1);
            clk_out_q <= (cnt_q + PW'(1)) < h_q;
          end
          // A request taken on the boundary cycle waits for the next boundary.
          if (accept_c) begin
            if (sel_oob_c) begin
              sel_err_q <= 1'b1;
            end else if (!sel_same_c) begin
              pend_q      <= 1'b1;
              pend_sel_q  <= bus.SEL;
              busy_q      <= 1'b1;
              sel_ready_q <= 1'b0;
            end
          end
        end
`ifdef GLITCHLESS_DIV_GAP_EN
        ST_GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_q <= ST_START;
          else gap_cnt_q <= gap_cnt_q + GW'(1);
        end
`endif
        default: state_q <= ST_START;
      endcase
    end
  end

  assign bus.CLK_OUT    = clk_out_q;
  assign bus.CLK_EN     = clk_en_q;
  assign bus.SEL_READY  = sel_ready_q;
  assign bus.SEL_ERR    = sel_err_q;
  assign bus.BUSY       = busy_q;
  assign bus.ACTIVE_SEL = active_q;
endmodule
